// File: rtl/vec_player.sv
// Vector playback engine: streams stored stimulus vectors and compacts the
// delayed responses into a MISR signature.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start after reset; memory loads accepted
// S_RUN   | one vector per cycle from mem[idx]
// S_DRAIN | RSP_LAT cycles letting the last responses reach the MISR
// S_DONE  | results held; memory loads and a new start accepted
module vec_player #(
  parameter int VEC_WIDTH = 32,
  parameter int VEC_DEPTH = 1024,
  parameter int RSP_WIDTH = 16,
  parameter int RSP_LAT   = 1,
  parameter logic [RSP_WIDTH-1:0] POLY = 16'h8016,
  localparam int ADDR_W   = $clog2(VEC_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [VEC_WIDTH-1:0] ld_data,
  input  logic [ADDR_W:0]      vec_length,
  input  logic                 loop_mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic [RSP_WIDTH-1:0] rsp_in,
  output logic [VEC_WIDTH-1:0] vec_out,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic [RSP_WIDTH-1:0] misr_sig,
  output logic [15:0]          pass_cnt,
  output logic [31:0]          vec_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int PW = (RSP_LAT > 0) ? RSP_LAT : 1;

  state_t               state;
  logic [VEC_WIDTH-1:0] mem [VEC_DEPTH];
  logic [ADDR_W-1:0]    idx;
  logic [ADDR_W-1:0]    idx_nxt;
  logic [ADDR_W:0]      len_q;
  logic [2:0]           drain_cnt;
  logic [PW-1:0]        vv_pipe;
  logic                 strobe;
  logic                 ld_ok;
  logic                 len_ok;
  logic                 last;
  logic [VEC_WIDTH-1:0] first_vec;
  logic [RSP_WIDTH-1:0] misr_next;

  assign ld_ok   = ld_en && (state == S_IDLE || state == S_DONE);
  assign len_ok  = (vec_length != '0) && (vec_length <= (ADDR_W+1)'(VEC_DEPTH));
  assign idx_nxt = idx + 1'b1;
  assign last    = ({1'b0, idx} == len_q - 1'b1);
  // A load to address 0 in the start cycle must be the first vector played.
  assign first_vec = (ld_ok && ld_addr == '0) ? ld_data : mem[0];
  assign misr_next = {misr_sig[RSP_WIDTH-2:0], 1'b0}
                   ^ (misr_sig[RSP_WIDTH-1] ? POLY : '0) ^ rsp_in;
  assign strobe    = (RSP_LAT == 0) ? vec_valid : vv_pipe[PW-1];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr] <= ld_data;
  end

  generate
    if (PW == 1) begin : g_pipe1
      always_ff @(posedge clk) begin
        if (rst) vv_pipe <= '0;
        else     vv_pipe <= vec_valid;
      end
    end else begin : g_pipen
      always_ff @(posedge clk) begin
        if (rst) vv_pipe <= '0;
        else     vv_pipe <= {vv_pipe[PW-2:0], vec_valid};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      misr_sig  <= '0;
      pass_cnt  <= '0;
      vec_cnt   <= '0;
      idx       <= '0;
      len_q     <= '0;
      drain_cnt <= '0;
    end else begin
      if (vec_valid) vec_cnt <= vec_cnt + 1'b1;
      if (strobe) misr_sig <= misr_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && len_ok) begin
            state     <= S_RUN;
            vec_out   <= first_vec;
            vec_valid <= 1'b1;
            idx       <= '0;
            len_q     <= vec_length;
            misr_sig  <= '0;
            pass_cnt  <= '0;
            vec_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (last && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 1'b1;
          if (stop || (last && !loop_mode)) begin
            vec_valid <= 1'b0;
            if (RSP_LAT == 0) begin
              state <= S_DONE;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= 3'(RSP_LAT - 1);
            end
          end else if (last) begin
            idx     <= '0;
            vec_out <= mem[0];
          end else begin
            idx     <= idx_nxt;
            vec_out <= mem[idx_nxt];
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_DONE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_player.sv
// Directed bench for vec_player (depth 16, RSP_LAT 1); responses are the
// low half of vec_out delayed by one cycle.
module tb_vec_player;

  localparam int VW = 32;
  localparam int VD = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [VW-1:0] ld_data = '0;
  logic [AW:0]   vec_length = '0;
  logic          loop_mode = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   rsp_in;
  logic [VW-1:0] vec_out;
  logic          vec_valid, busy, done;
  logic [15:0]   misr_sig, pass_cnt;
  logic [31:0]   vec_cnt;

  logic [15:0]   rsp_d = '0;
  logic [VW-1:0] tb_mem [VD];
  logic [15:0]   exp_misr;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rsp_d <= vec_out[15:0];
  assign rsp_in = rsp_d;

  vec_player #(.VEC_WIDTH(VW), .VEC_DEPTH(VD), .RSP_WIDTH(16), .RSP_LAT(1),
               .POLY(16'h8016)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .vec_length(vec_length), .loop_mode(loop_mode), .start(start), .stop(stop),
    .rsp_in(rsp_in), .vec_out(vec_out), .vec_valid(vec_valid), .busy(busy),
    .done(done), .misr_sig(misr_sig), .pass_cnt(pass_cnt), .vec_cnt(vec_cnt));

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] r);
    return ({m[14:0], 1'b0} ^ (m[15] ? 16'h8016 : 16'h0000)) ^ r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [VW-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic start_play(input int len, input logic lp);
    vec_length = (AW+1)'(len); loop_mode = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_misr", misr_sig, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_vcnt", vec_cnt, 0);
    rst = 1'b0;

    // basic single pass 1,2,3,4
    for (int i = 0; i < 4; i++) load(i, VW'(i + 1));
    start_play(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("basic_vec", vec_out, i + 1);
      chk("basic_valid", vec_valid, 1);
      @(negedge clk);
    end
    chk("basic_drain_valid", vec_valid, 0);
    chk("basic_drain_busy", busy, 1);
    chk("basic_drain_hold", vec_out, 4);
    chk("basic_drain_done", done, 0);
    @(negedge clk);
    chk("basic_done", done, 1);
    chk("basic_busy", busy, 0);
    chk("basic_pass", pass_cnt, 1);
    chk("basic_vcnt", vec_cnt, 4);
    chk("basic_misr", misr_sig, 16'h0002);

    // loop mode, stop after 7 vectors
    for (int i = 0; i < 3; i++) load(i, VW'(32'h10 + i));
    start_play(3, 1'b1);
    repeat (6) @(negedge clk);
    chk("loop_v7", vec_out, 32'h10);
    chk("loop_v7_valid", vec_valid, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", vec_valid, 0);
    chk("stop_hold", vec_out, 32'h10);
    chk("stop_busy", busy, 1);
    @(negedge clk);
    chk("stop_done", done, 1);
    chk("stop_pass", pass_cnt, 2);
    chk("stop_vcnt", vec_cnt, 7);

    // reset in the middle of a pass
    for (int i = 0; i < 4; i++) load(i, VW'(i + 1));
    start_play(4, 1'b0);
    @(negedge clk);
    chk("mid_v3_pre", vec_out, 2);
    @(negedge clk);
    chk("mid_v3", vec_out, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_vec", vec_out, 0);
    chk("mid_rst_valid", vec_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pass", pass_cnt, 0);
    chk("mid_rst_vcnt", vec_cnt, 0);
    @(negedge clk);
    chk("mid_rst_pipe_misr", misr_sig, 0);
    start_play(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("replay_vec", vec_out, i + 1);
      @(negedge clk);
    end
    @(negedge clk);
    chk("replay_done", done, 1);
    chk("replay_misr", misr_sig, 16'h0002);

    // illegal lengths ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_play(0, 1'b0);
    chk("len0_busy", busy, 0);
    chk("len0_valid", vec_valid, 0);
    chk("len0_done", done, 0);
    start_play(17, 1'b0);
    chk("len17_busy", busy, 0);
    chk("len17_valid", vec_valid, 0);

    // load+start+stop same cycle; loads and starts during RUN ignored
    ld_en = 1'b1; ld_addr = '0; ld_data = 32'h55; stop = 1'b1;
    start_play(4, 1'b0);
    ld_en = 1'b0; stop = 1'b0;
    chk("fwd_v1", vec_out, 32'h55);
    chk("fwd_busy", busy, 1);
    ld_en = 1'b1; ld_addr = '0; ld_data = 32'hDEAD;
    @(negedge clk);
    ld_en = 1'b0;
    chk("run_v2", vec_out, 2);
    start = 1'b1; vec_length = 5'd1;
    @(negedge clk);
    chk("run_v3", vec_out, 3);
    @(negedge clk);
    start = 1'b0;
    chk("run_v4", vec_out, 4);
    @(negedge clk);
    chk("run_drain", vec_valid, 0);
    @(negedge clk);
    chk("run_done_pass", pass_cnt, 1);
    start_play(1, 1'b0);
    chk("noload_v1", vec_out, 32'h55);
    @(negedge clk);
    chk("len1_drain", vec_valid, 0);
    @(negedge clk);
    chk("len1_done", done, 1);
    chk("len1_pass", pass_cnt, 1);
    chk("len1_vcnt", vec_cnt, 1);

    // full depth; loop_mode dropped mid-pass must end after this pass
    exp_misr = '0;
    for (int i = 0; i < VD; i++) begin
      tb_mem[i] = {16'hA5A5, 16'(i * 16'h1357 + 16'h8001)};
      load(i, tb_mem[i]);
      exp_misr = misr_step(exp_misr, tb_mem[i][15:0]);
    end
    start_play(VD, 1'b1);
    for (int i = 0; i < VD; i++) begin
      chk("full_vec", vec_out, tb_mem[i]);
      if (i == 8) loop_mode = 1'b0;
      @(negedge clk);
    end
    chk("full_no_wrap", vec_valid, 0);
    chk("full_hold", vec_out, tb_mem[VD-1]);
    @(negedge clk);
    chk("full_done", done, 1);
    chk("full_pass", pass_cnt, 1);
    chk("full_vcnt", vec_cnt, VD);
    chk("full_misr", misr_sig, exp_misr);
    @(negedge clk);
    chk("full_hold_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
